seg_scan_driver: RTL and testbench

- Parametrised successor to the single-digit hex-to-7-segment decoder.
- Drives an N-digit common-anode display through one time-multiplexed segment bus.
- Per-digit hex value, decimal point and blank, held in a load-latched shadow register.
- Prescaled scan counter walks the digits. Sits between the switch/button front end and the board's segment/anode pins.

---
 rtl/seg_scan_driver.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Purpose:
//   Drives an N-digit common-anode 7-segment display through one
//   time-multiplexed segment bus. Per-digit hex value, decimal point and
//   blank flags are captured into a shadow register on load. A prescaled
//   scan counter walks the digits. segment and anode are registered together,
//   so a digit change never shows a mix of two digits.
//
// Optional feature:
//   `define SEG_LZ_SUPPRESS_EN to build leading-zero suppression. Digit k>0 is
//   blanked when its nibble and every higher nibble are zero. Digit 0 is
//   never suppressed, and the decimal point is not affected. Without the
//   macro, zeros are displayed normally and no suppression logic is built.
//
// Parameters:
//   N_DIGITS  number of digits scanned (1..8)
//   SCAN_DIV  clock cycles each digit stays lit (>= 2)
//   IDX_W     width of digit_idx (derived, not overridable)
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   load       capture hex_in/dp_in/blank_in into the shadow register
//   hex_in     nibble k is the value for digit k (digit 0 = rightmost)
//   dp_in      1 = decimal point on for digit k
//   blank_in   1 = segments a-g off for digit k
//   enable     0 = display dark and scan frozen
//   segment    active-low segments, [0]=a .. [6]=g, [7]=p
//   anode      active-low digit select, one-hot-low
//   digit_idx  index of the currently lit digit
//   scan_tick  one-cycle pulse each time digit_idx advances
// ---------------------------------------------------------------------------
module seg_scan_driver #(
   parameter  int unsigned N_DIGITS = 4,
   parameter  int unsigned SCAN_DIV = 50000,
   localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] hex_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic                  enable,
   output logic [7:0]            segment,
   output logic [N_DIGITS-1:0]   anode,
   output logic [IDX_W-1:0]      digit_idx,
   output logic                  scan_tick
);

   localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   // Shadow register holding the displayed content.
   logic [4*N_DIGITS-1:0] hex_sh;
   logic [N_DIGITS-1:0]   dp_sh;
   logic [N_DIGITS-1:0]   blank_sh;

   // Scan state.
   logic [PRE_W-1:0]      pre;

   // Combinational next values for the output registers.
   logic [N_DIGITS-1:0]   hide_c;
   logic [3:0]            cur_hex_c;
   logic                  cur_dp_c;
   logic                  cur_hide_c;
   logic [7:0]            seg_next_c;
   logic [N_DIGITS-1:0]   anode_next_c;
   logic                  pre_last_c;
   logic [IDX_W-1:0]      idx_next_c;

   // Active-low a..g pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

`ifdef SEG_LZ_SUPPRESS_EN
   // Leading-zero detection: walk from the top digit down while nibbles are 0.
   logic [N_DIGITS-1:0] lz_c;

   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_c     = '0;
      for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
         zero_run = zero_run & (hex_sh[4*k +: 4] == 4'h0);
         lz_c[k]  = zero_run & (k != 0);
      end
   end

   assign hide_c = blank_sh | lz_c;
`else
   assign hide_c = blank_sh;
`endif

   // Select the current digit's shadow fields and form the next outputs.
   always_comb begin
      cur_hex_c    = 4'h0;
      cur_dp_c     = 1'b0;
      cur_hide_c   = 1'b0;
      anode_next_c = '1;
      for (int k = 0; k < int'(N_DIGITS); k++) begin
         if (digit_idx == IDX_W'(k)) begin
            cur_hex_c       = hex_sh[4*k +: 4];
            cur_dp_c        = dp_sh[k];
            cur_hide_c      = hide_c[k];
            anode_next_c[k] = 1'b0;
         end
      end
      seg_next_c = {~cur_dp_c, cur_hide_c ? 7'h7F : hex_to_seg(cur_hex_c)};
   end

   // Prescaler terminal count and digit wrap.
   always_comb begin
      pre_last_c = (pre == PRE_W'(SCAN_DIV - 1));
      if (digit_idx == IDX_W'(N_DIGITS - 1)) begin
         idx_next_c = '0;
      end else begin
         idx_next_c = digit_idx + IDX_W'(1);
      end
   end

   // Shadow capture, scan counters and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex_sh    <= '0;
         dp_sh     <= '0;
         blank_sh  <= '0;
         pre       <= '0;
         digit_idx <= '0;
         scan_tick <= 1'b0;
         segment   <= 8'hFF;
         anode     <= '1;
      end else begin
         if (load) begin
            hex_sh   <= hex_in;
            dp_sh    <= dp_in;
            blank_sh <= blank_in;
         end

         scan_tick <= 1'b0;
         if (enable) begin
            if (pre_last_c) begin
               pre       <= '0;
               digit_idx <= idx_next_c;
               scan_tick <= 1'b1;
            end else begin
               pre <= pre + PRE_W'(1);
            end
            // Outputs reflect the pre-edge digit and shadow contents.
            segment <= seg_next_c;
            anode   <= anode_next_c;
         end else begin
            segment <= 8'hFF;
            anode   <= '1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Purpose:
//   Self-checking bench for seg_scan_driver (N_DIGITS=4, SCAN_DIV=4).
//   The reference model tracks the number of enabled cycles since reset and
//   derives the lit digit, tick and decoded segments arithmetically.
//   Honours SEG_LZ_SUPPRESS_EN the same way as the design build.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int unsigned N  = 4;
   localparam int unsigned SD = 4;
   localparam int unsigned IW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           load;
   logic [4*N-1:0] hex_in;
   logic [N-1:0]   dp_in;
   logic [N-1:0]   blank_in;
   logic           enable;
   logic [7:0]     segment;
   logic [N-1:0]   anode;
   logic [IW-1:0]  digit_idx;
   logic           scan_tick;

   int passed = 0;
   int total  = 0;

   // Reference model state.
   logic [4*N-1:0] m_hex;
   logic [N-1:0]   m_dp;
   logic [N-1:0]   m_blank;
   int             m_en_cnt;
   logic [7:0]     m_seg;
   logic [N-1:0]   m_an;
   logic           m_tick;

   logic [7:0]     lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .hex_in    (hex_in),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .enable    (enable),
      .segment   (segment),
      .anode     (anode),
      .digit_idx (digit_idx),
      .scan_tick (scan_tick)
   );

   always #5 clk = ~clk;

   function automatic int m_digit();
      return (m_en_cnt / int'(SD)) % int'(N);
   endfunction

   function automatic logic [7:0] m_decode(input int d);
      logic [3:0] nib;
      logic       hide;
      logic [7:0] base;
      nib  = 4'(m_hex >> (4 * d));
      hide = m_blank[d];
`ifdef SEG_LZ_SUPPRESS_EN
      if (d > 0 && (m_hex >> (4 * d)) == 0) hide = 1'b1;
`endif
      base = lut[nib];
      return {~m_dp[d], hide ? 7'h7F : base[6:0]};
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      int d;
      logic [N-1:0] one;
      one = 1;
      if (!rst_n) begin
         m_hex    = '0;
         m_dp     = '0;
         m_blank  = '0;
         m_en_cnt = 0;
         m_seg    = 8'hFF;
         m_an     = '1;
         m_tick   = 1'b0;
      end else begin
         d = m_digit();
         if (enable) begin
            m_seg    = m_decode(d);
            m_an     = ~(one << d);
            m_tick   = ((m_en_cnt % int'(SD)) == int'(SD) - 1);
            m_en_cnt = m_en_cnt + 1;
         end else begin
            m_seg  = 8'hFF;
            m_an   = '1;
            m_tick = 1'b0;
         end
         if (load) begin
            m_hex   = hex_in;
            m_dp    = dp_in;
            m_blank = blank_in;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("segment",   32'(segment),   32'(m_seg));
      chk("anode",     32'(anode),     32'(m_an));
      chk("digit_idx", 32'(digit_idx), 32'(m_digit()));
      chk("scan_tick", 32'(scan_tick), 32'(m_tick));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the model sits on digit d with prescaler phase ph (bounded).
   task automatic run_to(input int d, input int ph);
      int found;
      found = 0;
      for (int i = 0; i < 64; i++) begin
         if (m_digit() == d && (m_en_cnt % int'(SD)) == ph) begin
            found = 1;
            break;
         end
         step();
      end
      chk("run_to_reached", 32'(found), 32'd1);
   endtask

   task automatic load_val(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
      hex_in   = h;
      dp_in    = dp;
      blank_in = bl;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   initial begin
      // Reset with random inputs, load and enable active.
      rst_n    = 1'b0;
      load     = 1'b1;
      enable   = 1'b1;
      hex_in   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom);
      m_en_cnt = 0;
      model_edge();
      @(posedge clk);
      #1;
      chk("rst_segment",   32'(segment),   32'hFF);
      chk("rst_anode",     32'(anode),     32'hF);
      chk("rst_digit_idx", 32'(digit_idx), 32'd0);
      chk("rst_scan_tick", 32'(scan_tick), 32'd0);
      hex_in = 16'($urandom);
      steps(2);

      // Scan of 12AF, plain digits.
      rst_n  = 1'b1;
      enable = 1'b0;
      load_val(16'h12AF, 4'b0000, 4'b0000);
      enable = 1'b1;
      steps(3 * int'(SD) * int'(N) + 3);

      // Decimal point and blank.
      load_val(16'h12AF, 4'b0010, 4'b1001);
      steps(2 * int'(SD) * int'(N));

      // Freeze two cycles into digit 2, then resume.
      load_val(16'h12AF, 4'b0000, 4'b0000);
      run_to(2, 2);
      enable = 1'b0;
      steps(3);
      enable = 1'b1;
      steps(10);

      // Load mid-scan while digit 1 is lit, then ignore hex_in without load.
      run_to(1, 1);
      load_val(16'h0005, 4'b0000, 4'b0000);
      hex_in = 16'hFFFF;
      steps(2 * int'(SD) * int'(N));

      // Mid-scan reset on digit 2.
      run_to(2, 1);
      rst_n = 1'b0;
      step();
      chk("midrst_digit_idx", 32'(digit_idx), 32'd0);
      rst_n = 1'b1;
      load_val(16'h3C7E, 4'b0101, 4'b0000);
      steps(int'(SD) * int'(N) + 2);

      // Leading-zero patterns (displayed normally when the feature is off).
      load_val(16'h0005, 4'b0000, 4'b0000);
      steps(int'(SD) * int'(N) + 1);
      load_val(16'h0000, 4'b0000, 4'b0000);
      steps(int'(SD) * int'(N) + 1);
      load_val(16'h0100, 4'b1000, 4'b0000);
      steps(int'(SD) * int'(N) + 1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rst_n    = ($urandom_range(0, 60) != 0);
         enable   = ($urandom_range(0, 5) != 0);
         load     = ($urandom_range(0, 7) == 0);
         hex_in   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 16'h00FF)) : 16'($urandom);
         dp_in    = 4'($urandom);
         blank_in = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
